dir_cmd_queue: RTL and testbench
================================

Name: dir_cmd_queue

Overview:
- Sits between the PS/2 `keyboard` receiver and the snake-motion logic.
- Decodes Set-2 scancode bytes (prefixes E0/F0, make/break) into direction commands.
- Filters out redundant and reversing commands, buffers them in a small FIFO, and releases one per game tick as the applied snake direction.
- Also emits a one-cycle start pulse on the space key.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2)
- RESET_DIR, 2'd1, direction loaded on reset/clear (0=up, 1=right, 2=down, 3=left)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- key  in  8  scancode byte from keyboard
- key_rdy  in  1  one-cycle strobe: key valid
- step  in  1  game tick; pops one command
- clear  in  1  synchronous flush (new game); same effect as rst except overflow
- snake_dir  out  2  applied direction, registered
- start  out  1  one-cycle pulse on space make code
- level  out  $clog2(DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky: command dropped because FIFO full; cleared only by rst

Behaviour:
- Reset (rst=1): FSM=IDLE, FIFO empty, level=0, snake_dir=RESET_DIR, start=0, overflow=0.
- clear=1: same as reset, but overflow is kept. clear has priority over key_rdy/step in the same cycle.
- Prefix FSM advances only on key_rdy=1:
  - IDLE: E0→EXT; F0→BRK; else decode as plain make.
  - EXT: F0→EXT_BRK; else decode as extended make, →IDLE.
  - BRK: any byte → IDLE (break discarded).
  - EXT_BRK: any byte → IDLE (discarded).
- Extended makes: 75=up(0), 74=right(1), 72=down(2), 6B=left(3). Other extended bytes are ignored.
- Plain make 29 (space): start=1 on the next cycle for exactly one cycle. No FIFO effect.
- Reference direction R = FIFO tail entry if level>0, else snake_dir.
- Push candidate d is accepted only if d≠R and d≠R^2'b10 (not a reversal). Otherwise it is silently dropped, with no overflow.
- Accepted d with level==DEPTH: dropped and overflow←1.
- step=1 with level>0: snake_dir←head on the next edge, head removed, level decremented.
- step=1 with level==0: snake_dir holds.
- Same-cycle push and pop:
  - R is evaluated before the pop.
  - Both operations occur; level is unchanged.
  - A push into an empty FIFO is not visible to that cycle's pop.
  - A push on a full FIFO with a simultaneous pop is accepted (the pop frees the slot); overflow is not set.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. level is the separate counter.
- Latency:
  - key_rdy of the final byte → entry in FIFO: 1 cycle.
  - step → snake_dir update: 1 cycle.
- All outputs are registered. No combinational path from inputs to outputs.

Optional Feature:
- Macro DIR_CMD_QUEUE_WASD_EN.
- When defined, plain (non-E0) makes 1D=up, 23=right, 1B=down, 1C=left are also decoded as direction commands, with identical filtering.
- When undefined, those bytes are ignored like any other plain byte.

Test Plan:
- Reset, then key bytes E0,75 then step → level 1 after the bytes; snake_dir=0 one cycle after step; level 0.
- With snake_dir=1 and FIFO empty, send E0,6B (left, a reversal) and E0,74 (right, the same direction) → level stays 0, overflow=0.
- Enqueue up, left, down, right, up (each valid against the previous tail) with DEPTH=4 → level=4, overflow=1. Four steps yield snake_dir 0,3,2,1.
- Send E0,F0,75 (break) and F0,29 → no push, no start. Then send 29 → start high for exactly one cycle.
- With FIFO full, push a valid command in the same cycle as step → level stays 4, overflow stays 0, and the new entry appears last.
- Assert clear mid-sequence after E0 → FSM returns to IDLE; a following 75 alone is ignored; snake_dir=RESET_DIR. With the WASD macro defined, byte 1D then pushes up.

Source files
------------

// File: rtl/dir_cmd_queue_if.sv
// ============================================================================
// Module   : dir_cmd_queue_if
// Brief    : Key/tick inputs and direction/status outputs of dir_cmd_queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dir_cmd_queue_if #(
   parameter int DEPTH = 4
);
   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic [7:0]       key;
   logic             key_rdy;
   logic             step;
   logic             clear;
   logic [1:0]       snake_dir;
   logic             start;
   logic [LVL_W-1:0] level;
   logic             overflow;

   modport master (
      output key, key_rdy, step, clear,
      input  snake_dir, start, level, overflow
   );

   modport slave (
      input  key, key_rdy, step, clear,
      output snake_dir, start, level, overflow
   );
endinterface

`default_nettype wire

// File: rtl/dir_cmd_queue.sv
// ============================================================================
// Module   : dir_cmd_queue
// Brief    : Set-2 scancode decoder feeding a filtered direction-command FIFO,
//            released one entry per game tick. Optional WASD decode under
//            macro DIR_CMD_QUEUE_WASD_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dir_cmd_queue #(
   parameter int         DEPTH     = 4,
   parameter logic [1:0] RESET_DIR = 2'd1
) (
   input  wire logic      clk,
   input  wire logic      rst,
   dir_cmd_queue_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH) + 1;

   localparam logic [7:0] C_KEY_EXT   = 8'hE0;
   localparam logic [7:0] C_KEY_BRK   = 8'hF0;
   localparam logic [7:0] C_KEY_SPACE = 8'h29;
   localparam logic [7:0] C_KEY_UP    = 8'h75;
   localparam logic [7:0] C_KEY_RIGHT = 8'h74;
   localparam logic [7:0] C_KEY_DOWN  = 8'h72;
   localparam logic [7:0] C_KEY_LEFT  = 8'h6B;
`ifdef DIR_CMD_QUEUE_WASD_EN
   localparam logic [7:0] C_KEY_W     = 8'h1D;
   localparam logic [7:0] C_KEY_D     = 8'h23;
   localparam logic [7:0] C_KEY_S     = 8'h1B;
   localparam logic [7:0] C_KEY_A     = 8'h1C;
`endif

   localparam logic [1:0] C_DIR_UP    = 2'd0;
   localparam logic [1:0] C_DIR_RIGHT = 2'd1;
   localparam logic [1:0] C_DIR_DOWN  = 2'd2;
   localparam logic [1:0] C_DIR_LEFT  = 2'd3;

   localparam logic [LVL_W-1:0] C_LVL_FULL = LVL_W'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXT     = 2'd1,
      ST_BRK     = 2'd2,
      ST_EXT_BRK = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_cand_vld;
   logic [1:0]       w_cand_dir;
   logic             w_space;

   logic [1:0]       r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] w_tail_ptr;
   logic [LVL_W-1:0] r_level;
   logic [1:0]       r_snake_dir;
   logic             r_start;
   logic             r_overflow;

   logic             w_empty;
   logic             w_full;
   logic [1:0]       w_ref_dir;
   logic             w_accept;
   logic             w_push;
   logic             w_pop;
   logic             w_drop_full;

   // ------------------------------------------------------------------
   // Prefix FSM and make-code decode
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst || bus.clear) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cand_vld  = 1'b0;
      w_cand_dir  = C_DIR_UP;
      w_space     = 1'b0;
      if (bus.key_rdy) begin
         case (r_state)
            ST_IDLE: begin
               if (bus.key == C_KEY_EXT) begin
                  w_state_nxt = ST_EXT;
               end else if (bus.key == C_KEY_BRK) begin
                  w_state_nxt = ST_BRK;
               end else begin
                  w_space = (bus.key == C_KEY_SPACE);
`ifdef DIR_CMD_QUEUE_WASD_EN
                  case (bus.key)
                     C_KEY_W: begin w_cand_vld = 1'b1; w_cand_dir = C_DIR_UP;    end
                     C_KEY_D: begin w_cand_vld = 1'b1; w_cand_dir = C_DIR_RIGHT; end
                     C_KEY_S: begin w_cand_vld = 1'b1; w_cand_dir = C_DIR_DOWN;  end
                     C_KEY_A: begin w_cand_vld = 1'b1; w_cand_dir = C_DIR_LEFT;  end
                     default: ;
                  endcase
`endif
               end
            end
            ST_EXT: begin
               if (bus.key == C_KEY_BRK) begin
                  w_state_nxt = ST_EXT_BRK;
               end else begin
                  w_state_nxt = ST_IDLE;
                  case (bus.key)
                     C_KEY_UP:    begin w_cand_vld = 1'b1; w_cand_dir = C_DIR_UP;    end
                     C_KEY_RIGHT: begin w_cand_vld = 1'b1; w_cand_dir = C_DIR_RIGHT; end
                     C_KEY_DOWN:  begin w_cand_vld = 1'b1; w_cand_dir = C_DIR_DOWN;  end
                     C_KEY_LEFT:  begin w_cand_vld = 1'b1; w_cand_dir = C_DIR_LEFT;  end
                     default: ;
                  endcase
               end
            end
            ST_BRK:     w_state_nxt = ST_IDLE;
            ST_EXT_BRK: w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Command filter and FIFO control
   // ------------------------------------------------------------------
   // Reference is the newest queued command, so filtering applies to what
   // the snake will be doing once the queue drains up to this point.
   always_comb begin
      w_tail_ptr  = r_wr_ptr - PTR_W'(1);
      w_empty     = (r_level == '0);
      w_full      = (r_level == C_LVL_FULL);
      w_ref_dir   = w_empty ? r_snake_dir : r_mem[w_tail_ptr];
      w_accept    = w_cand_vld
                    && (w_cand_dir != w_ref_dir)
                    && (w_cand_dir != (w_ref_dir ^ 2'b10));
      w_pop       = bus.step && !w_empty;
      w_push      = w_accept && (!w_full || w_pop);
      w_drop_full = w_accept && w_full && !w_pop;
   end

   always_ff @(posedge clk) begin
      if (w_push && !rst && !bus.clear) begin
         r_mem[r_wr_ptr] <= w_cand_dir;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || bus.clear) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_snake_dir <= RESET_DIR;
         r_start     <= 1'b0;
      end else begin
         r_start <= w_space;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr    <= r_rd_ptr + PTR_W'(1);
            r_snake_dir <= r_mem[r_rd_ptr];
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LVL_W'(1);
            2'b01:   r_level <= r_level - LVL_W'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // Sticky across clear so a new game does not hide a dropped command.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_overflow <= 1'b0;
      end else if (!bus.clear && w_drop_full) begin
         r_overflow <= 1'b1;
      end
   end

   assign bus.snake_dir = r_snake_dir;
   assign bus.start     = r_start;
   assign bus.level     = r_level;
   assign bus.overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_dir_cmd_queue.sv
// ============================================================================
// Module   : tb_dir_cmd_queue
// Brief    : Scoreboard bench: directed plan sequences then random scancodes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dir_cmd_queue;
   localparam int         DEPTH     = 4;
   localparam logic [1:0] RESET_DIR = 2'd1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dir_cmd_queue_if #(.DEPTH(DEPTH)) bus ();

   dir_cmd_queue #(.DEPTH(DEPTH), .RESET_DIR(RESET_DIR)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [1:0] dir;
      logic       start;
      int         level;
      logic       ovf;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Reference model state
   logic       m_saw_e0;
   logic       m_saw_f0;
   logic [1:0] m_dir;
   logic [1:0] m_q[$];
   logic       m_ovf;
   logic       m_start;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic model(input logic [7:0] k, input logic rdy, input logic stp,
                        input logic clr, input logic reset);
      logic       cand_vld;
      logic [1:0] cand;
      logic [1:0] refd;
      logic       popping;
      logic [1:0] head;
      cand_vld = 1'b0;
      cand     = 2'd0;
      if (reset || clr) begin
         m_saw_e0 = 1'b0;
         m_saw_f0 = 1'b0;
         m_q.delete();
         m_dir    = RESET_DIR;
         m_start  = 1'b0;
         if (reset) m_ovf = 1'b0;
         return;
      end
      m_start = 1'b0;
      if (rdy) begin
         if (m_saw_f0) begin
            m_saw_e0 = 1'b0;
            m_saw_f0 = 1'b0;
         end else if (k == 8'hF0) begin
            m_saw_f0 = 1'b1;
         end else if (k == 8'hE0 && !m_saw_e0) begin
            m_saw_e0 = 1'b1;
         end else if (m_saw_e0) begin
            m_saw_e0 = 1'b0;
            case (k)
               8'h75: begin cand_vld = 1'b1; cand = 2'd0; end
               8'h74: begin cand_vld = 1'b1; cand = 2'd1; end
               8'h72: begin cand_vld = 1'b1; cand = 2'd2; end
               8'h6B: begin cand_vld = 1'b1; cand = 2'd3; end
               default: ;
            endcase
         end else begin
            if (k == 8'h29) m_start = 1'b1;
`ifdef DIR_CMD_QUEUE_WASD_EN
            case (k)
               8'h1D: begin cand_vld = 1'b1; cand = 2'd0; end
               8'h23: begin cand_vld = 1'b1; cand = 2'd1; end
               8'h1B: begin cand_vld = 1'b1; cand = 2'd2; end
               8'h1C: begin cand_vld = 1'b1; cand = 2'd3; end
               default: ;
            endcase
`endif
         end
      end
      refd    = (m_q.size() > 0) ? m_q[$] : m_dir;
      popping = stp && (m_q.size() > 0);
      head    = popping ? m_q[0] : 2'd0;
      if (popping) begin
         void'(m_q.pop_front());
         m_dir = head;
      end
      if (cand_vld && cand != refd && cand != (refd ^ 2'b10)) begin
         if (m_q.size() < DEPTH) m_q.push_back(cand);
         else                    m_ovf = 1'b1;
      end
   endtask

   task automatic cycle(input logic [7:0] k, input logic rdy, input logic stp,
                        input logic clr, input logic reset);
      exp_t e;
      @(negedge clk);
      rst         = reset;
      bus.key     = k;
      bus.key_rdy = rdy;
      bus.step    = stp;
      bus.clear   = clr;
      model(k, rdy, stp, clr, reset);
      e.dir   = m_dir;
      e.start = m_start;
      e.level = m_q.size();
      e.ovf   = m_ovf;
      exp_q.push_back(e);
   endtask

   task automatic send(input logic [7:0] k);
      cycle(k, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      cycle(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      cycle(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Monitor: compares every registered output one edge after its stimulus
   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("snake_dir", 32'(bus.snake_dir), 32'(e.dir));
         chk("start",     32'(bus.start),     32'(e.start));
         chk("level",     32'(bus.level),     32'(e.level));
         chk("overflow",  32'(bus.overflow),  32'(e.ovf));
      end
   end

   logic [7:0] pool [12];

   initial begin
      logic [7:0] k;
      bus.key = 8'h00; bus.key_rdy = 1'b0; bus.step = 1'b0; bus.clear = 1'b0;
      m_saw_e0 = 1'b0; m_saw_f0 = 1'b0; m_dir = RESET_DIR; m_ovf = 1'b0; m_start = 1'b0;
      pool = '{8'hE0, 8'hF0, 8'h75, 8'h74, 8'h72, 8'h6B, 8'h29,
               8'h1D, 8'h23, 8'h1B, 8'h1C, 8'h5A};

      // Extended up, then one tick applies it
      do_reset();
      send(8'hE0); send(8'h75); idle(1);
      chk("plan_level_after_up", 32'(bus.level), 32'd1);
      tick(); idle(1);
      chk("plan_dir_after_step", 32'(bus.snake_dir), 32'd0);
      chk("plan_level_after_step", 32'(bus.level), 32'd0);

      // Reversal and same-direction commands are dropped
      do_reset();
      send(8'hE0); send(8'h6B); send(8'hE0); send(8'h74); idle(1);
      chk("plan_filter_level", 32'(bus.level), 32'd0);
      chk("plan_filter_ovf", 32'(bus.overflow), 32'd0);

      // Five valid commands into a four-deep queue
      send(8'hE0); send(8'h75); send(8'hE0); send(8'h6B);
      send(8'hE0); send(8'h72); send(8'hE0); send(8'h74);
      send(8'hE0); send(8'h75); idle(1);
      chk("plan_full_level", 32'(bus.level), 32'd4);
      chk("plan_full_ovf", 32'(bus.overflow), 32'd1);
      for (int i = 0; i < 4; i++) begin tick(); idle(1); end

      // Breaks never push or start; a plain space does
      send(8'hE0); send(8'hF0); send(8'h75);
      send(8'hF0); send(8'h29); idle(2);
      send(8'h29); idle(2);

      // Push on a full queue in the same cycle as a pop
      do_reset();
      send(8'hE0); send(8'h75); send(8'hE0); send(8'h6B);
      send(8'hE0); send(8'h72); send(8'hE0); send(8'h74);
      send(8'hE0);
      cycle(8'h75, 1'b1, 1'b1, 1'b0, 1'b0); idle(1);
      chk("plan_swap_level", 32'(bus.level), 32'd4);
      chk("plan_swap_ovf", 32'(bus.overflow), 32'd0);
      for (int i = 0; i < 4; i++) begin tick(); idle(1); end
      chk("plan_swap_last", 32'(bus.snake_dir), 32'd0);

      // Clear in the middle of a prefix sequence
      send(8'hE0);
      cycle(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      send(8'h75); idle(1);
      chk("plan_clear_level", 32'(bus.level), 32'd0);
      chk("plan_clear_dir", 32'(bus.snake_dir), 32'(RESET_DIR));
`ifdef DIR_CMD_QUEUE_WASD_EN
      send(8'h1D); idle(1);
      chk("plan_wasd_level", 32'(bus.level), 32'd1);
`endif

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         k = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 11)];
         cycle(k,
               ($urandom_range(0, 9) < 6),
               ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 99) < 2),
               ($urandom_range(0, 299) == 0));
      end

      idle(3);
      @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
